// File: rtl/wb_byte_master_pkg.sv
// Shared opcodes, status codes, state encoding and timeout sizing for wb_byte_master.
package wb_byte_master_pkg;

    localparam logic [7:0] OP_WRITE_DEF = 8'hA1;
    localparam logic [7:0] OP_READ_DEF  = 8'hA2;

    localparam logic [7:0] STAT_OK      = 8'h00;
    localparam logic [7:0] STAT_TIMEOUT = 8'h01;
    localparam logic [7:0] STAT_BADOP   = 8'hEE;

    typedef enum logic [2:0] {
        StIdle,
        StOpc,
        StAddr,
        StWdata,
        StBus,
        StResp
    } state_e;

    // Counter width able to hold the value TIMEOUT_CYCLES itself.
    function automatic int unsigned tmo_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_byte_shifter.sv
// 4-byte MSB-first register: clear, parallel load, or shift a byte in at the bottom.
module wb_byte_shifter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [31:0] i_load_word,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_at_last
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (i_clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (i_load) begin
            word_d = i_load_word;
            cnt_d  = '0;
        end else if (i_shift) begin
            word_d = {word_q[23:0], i_byte};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_word    = word_q;
    // Next shifted byte completes the word.
    assign o_at_last = (cnt_q == 2'd3);

endmodule

// File: rtl/wb_byte_master.sv
// Byte-stream command parser driving single classic Wishbone cycles with byte-stream responses.
// Optional bus timeout enabled by defining WB_BYTE_MASTER_TIMEOUT_EN.
module wb_byte_master
    import wb_byte_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  OP_WRITE       = OP_WRITE_DEF,
    parameter logic [7:0]  OP_READ        = OP_READ_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_stb,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    output logic        o_busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_tmo_range
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        stb_q, stb_d;
    logic [7:0]  status_q, status_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  resp_last;
    logic        rx_fire, tx_fire;
    logic        adr_clr, adr_shift, adr_at_last;
    logic        dat_clr, dat_load, dat_shift, dat_at_last;
    logic [31:0] adr_word, dat_word;

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
    localparam int unsigned TW        = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q, tmo_d, tmo_next;
    assign tmo_next = tmo_q + TW'(1);
`endif

    assign rx_fire   = i_rx_valid && o_rx_ready;
    assign tx_fire   = o_tx_valid && i_tx_ready;
    // Only a successful read carries the 4 data bytes after the status byte.
    assign resp_last = (!we_q && status_q == STAT_OK) ? 3'd4 : 3'd0;

    wb_byte_shifter u_adr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (adr_clr),
        .i_load      (1'b0),
        .i_load_word (32'h0),
        .i_shift     (adr_shift),
        .i_byte      (i_rx_data),
        .o_word      (adr_word),
        .o_at_last   (adr_at_last)
    );

    // Holds write data on the way in and read data on the way out.
    wb_byte_shifter u_dat (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (dat_clr),
        .i_load      (dat_load),
        .i_load_word (i_wb_dat),
        .i_shift     (dat_shift),
        .i_byte      (i_rx_data),
        .o_word      (dat_word),
        .o_at_last   (dat_at_last)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        stb_d     = stb_q;
        status_d  = status_q;
        idx_d     = idx_q;
        adr_clr   = 1'b0;
        adr_shift = 1'b0;
        dat_clr   = 1'b0;
        dat_load  = 1'b0;
        dat_shift = 1'b0;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
        tmo_d     = '0;
`endif
        unique case (state_q)
            StIdle: state_d = StOpc;
            StOpc: begin
                if (rx_fire) begin
                    if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) begin
                        we_d    = (i_rx_data == OP_WRITE);
                        adr_clr = 1'b1;
                        dat_clr = 1'b1;
                        state_d = StAddr;
                    end else begin
                        status_d = STAT_BADOP;
                        idx_d    = '0;
                        state_d  = StResp;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    adr_shift = 1'b1;
                    if (adr_at_last) begin
                        if (we_q) begin
                            state_d = StWdata;
                        end else begin
                            state_d = StBus;
                            stb_d   = 1'b1;
                        end
                    end
                end
            end
            StWdata: begin
                if (rx_fire) begin
                    dat_shift = 1'b1;
                    if (dat_at_last) begin
                        state_d = StBus;
                        stb_d   = 1'b1;
                    end
                end
            end
            StBus: begin
                if (stb_q) begin
                    // ACK wins over a simultaneous timeout.
                    if (i_wb_ack) begin
                        stb_d    = 1'b0;
                        status_d = STAT_OK;
                        idx_d    = '0;
                        dat_load = !we_q;
                        state_d  = StResp;
                    end
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
                    else if (tmo_next == TMO_LIMIT) begin
                        stb_d    = 1'b0;
                        status_d = STAT_TIMEOUT;
                        idx_d    = '0;
                        state_d  = StResp;
                    end else begin
                        tmo_d = tmo_next;
                    end
`endif
                end
            end
            StResp: begin
                if (tx_fire) begin
                    if (idx_q == resp_last) begin
                        state_d = StIdle;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        dat_shift = (idx_q != 3'd0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            stb_q    <= 1'b0;
            status_q <= 8'h00;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            stb_q    <= stb_d;
            status_q <= status_d;
            idx_q    <= idx_d;
        end
    end

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign o_rx_ready = (state_q == StOpc) || (state_q == StAddr) || (state_q == StWdata);
    assign o_busy     = (state_q != StIdle);
    assign o_tx_valid = (state_q == StResp);
    assign o_tx_data  = (state_q != StResp) ? 8'h00 :
                        (idx_q == 3'd0)     ? status_q : dat_word[31:24];
    assign o_wb_adr   = adr_word;
    assign o_wb_dat   = dat_word;
    assign o_wb_we    = we_q;
    assign o_wb_sel   = stb_q ? 4'hF : 4'h0;
    assign o_wb_stb   = stb_q;
    assign o_wb_cyc   = stb_q;

endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
- Wishbone initiator driven by a byte-stream command channel, e.g. an SPI/UART slave byte interface from the host.
- Parses single-word read/write commands, runs one classic Wishbone cycle per command, and returns a status/data response on a byte-stream output.
- Acts as the bus-master counterpart to peripheral register slaves such as the protocol mode register at 0x40000700.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles STB held awaiting ACK before abort; valid range 1..65535.
- OP_WRITE, 8'hA1: write opcode.
- OP_READ, 8'hA2: read opcode.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  command byte
- i_rx_valid  in  1  command byte valid
- o_rx_ready  out  1  command byte accepted when valid&&ready
- o_tx_data  out  8  response byte
- o_tx_valid  out  1  response byte valid
- i_tx_ready  in  1  response byte consumed when valid&&ready
- o_wb_adr  out  32  bus address
- o_wb_dat  out  32  write data
- o_wb_we  out  1  write enable
- o_wb_sel  out  4  byte selects; always 4'hF during a cycle
- o_wb_stb  out  1  strobe
- o_wb_cyc  out  1  cycle; equal to o_wb_stb
- i_wb_dat  in  32  read data
- i_wb_ack  in  1  acknowledge
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk. All outputs 0, state IDLE, internal counters 0.
- Reset mid-cycle drops STB/CYC on the next edge. Any partial command or response is discarded.
- Command format:
  - Write: opcode, 4 address bytes (MSB first), 4 data bytes (MSB first).
  - Read: opcode, 4 address bytes.
- Response format:
  - Status byte: 8'h00 OK, 8'h01 timeout, 8'hEE bad opcode.
  - A successful read appends 4 data bytes, MSB first. Timed-out reads append nothing.
- o_rx_ready is high only in OPC, ADDR, WDATA.
- States:
  - IDLE→OPC is immediate: OPC is the waiting state. IDLE exists only for one cycle after reset and after a response completes.
  - OPC:
    - On accept of OP_WRITE or OP_READ → ADDR with byte counter=0; latch we.
    - On any other opcode → RESP with status EE and no bus cycle.
  - ADDR: shift each accepted byte into the address register. After the 4th byte → WDATA if write, else BUS.
  - WDATA: shift 4 bytes into the data register, then → BUS.
  - BUS:
    - o_wb_stb=o_wb_cyc=1 starting the cycle after entry; adr, dat, we, sel are stable for the whole cycle.
    - The timeout counter increments each cycle STB is high without ACK.
    - On i_wb_ack while STB is high: deassert STB next edge, latch i_wb_dat if read, status 00 → RESP.
    - If the counter reaches TIMEOUT_CYCLES without ACK: deassert STB, status 01 → RESP.
    - ACK arriving in the same cycle the counter hits the limit counts as success.
  - RESP: present bytes in order. Hold o_tx_data stable while o_tx_valid && !i_tx_ready. After the final byte is accepted → IDLE.
- ACK while STB is low is ignored.
- At most one bus cycle is outstanding; no pipelining.
- Minimum latency: last command byte accepted → STB high 1 cycle later. ACK → first o_tx_valid 1 cycle later.

Optional Feature:
- Macro WB_BYTE_MASTER_TIMEOUT_EN.
- Defined: the timeout counter and status 01 path are present as above.
- Undefined: no counter; BUS waits indefinitely for ACK; status is always 00 or EE.

Decomposition:
- Shared package holds:
  - opcode constants;
  - status codes STAT_OK/STAT_TIMEOUT/STAT_BADOP;
  - state enum (IDLE, OPC, ADDR, WDATA, BUS, RESP);
  - TIMEOUT width derivation.
- One natural sub-module: wb_byte_shifter, a 4-byte MSB-first load/shift register with a byte counter. It is used for address, write data, and read-data serialization.

Test Plan:
- Write: A1 40 00 07 00 00 00 00 02, slave ACKs after 2 cycles → one cycle with adr=0x40000700, dat=0x2, we=1, sel=F; response 00.
- Read: A2 40 00 07 00, slave returns 0x00000002 with ACK → we=0; response 00 00 00 00 02.
- Timeout: A2 12 34 56 78 with no ACK → STB high exactly TIMEOUT_CYCLES cycles then drops; response single 01.
- Bad opcode: 5A → no STB; response EE; the next valid write command executes normally.
- Backpressure/gaps: gaps between rx bytes, and i_tx_ready low 3 cycles per byte on a read response → correct byte order, o_tx_data stable while stalled.
- Reset mid-BUS: assert i_rst while STB high → STB/CYC/tx_valid 0 next edge; a subsequent write succeeds.
